load_align_unit: RTL
====================

// Module: load_align_unit
// PURPOSE
//  Parametrised load-data path placed between the LSU address stage and the data memory port.
//  Accepts one load at a time and issues one or two aligned word reads.
//  Merges the word(s), shifts the addressed bytes to bit 0, then sign/zero-extends per funct3.
//  Result and a fault flag are presented to writeback on a valid/ready handshake.
// PARAMETERS
//  XLEN       32  data/address width; 32 or 64 (LD/LWU legal only when 64)
//  SPLIT_MIS  1   1: word-crossing misaligned loads split into two reads; 0: they fault
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     reset, asynchronous, active-high
//  req_valid     in   1     load request valid
//  req_ready     out  1     unit idle, request accepted when valid&ready
//  req_addr      in   XLEN  byte address
//  req_funct3    in   3     LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110
//  req_rd        in   5     destination tag, returned unchanged
//  mem_req_valid out  1     memory read request
//  mem_req_ready in   1     memory accepts request
//  mem_addr      out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
//  mem_rsp_valid in   1     read data valid (>=1 cycle after accepted request)
//  mem_rsp_data  in   XLEN  read word
//  wb_valid      out  1     result valid
//  wb_ready      in   1     writeback accepts result
//  wb_data       out  XLEN  extended load data (0 on fault)
//  wb_rd         out  5     tag of completed load
//  wb_fault      out  1     illegal funct3 or disallowed misaligned access
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 except req_ready=1. Internal regs cleared. Reset mid-operation abandons the load; no wb.
//  - FSM: IDLE -> REQ0 -> WAIT0 -> {REQ1 -> WAIT1 ->} RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid, latch addr/funct3/rd. Size = 1/2/4/8 bytes. off = addr mod (XLEN/8).
//    - Fault (funct3 111; LD/LWU with XLEN=32; off+size>XLEN/8 with SPLIT_MIS=0): go to RESP, wb_fault=1, wb_data=0.
//    - No memory request is issued in the fault case.
//    - Otherwise go to REQ0. Split = off+size>XLEN/8.
//  - REQ0/REQ1: mem_req_valid=1. mem_addr=aligned addr (REQ1: aligned addr + XLEN/8, mod 2^XLEN wrap).
//    Hold stable until mem_req_ready; then go to WAIT0/WAIT1.
//  - WAIT0: on mem_rsp_valid, capture lo word; go to REQ1 if split, else RESP.
//  - WAIT1: on mem_rsp_valid, capture hi word; go to RESP.
//  - mem_rsp_valid outside WAIT0/WAIT1 is ignored.
//  - Merge: ({hi,lo} >> 8*off)[XLEN-1:0]; hi=0 when not split.
//  - Extension: LB/LH/LW sign-extend from bit 7/15/31. LBU/LHU/LWU zero-extend. LD/LW(XLEN=32) pass through.
//  - RESP: wb_valid=1 with wb_data/wb_rd/wb_fault registered and stable until wb_ready. Then IDLE.
//    req_ready is 0 in RESP (no same-cycle accept).
//  - Latency, zero-wait memory: accept at cycle 0; mem_req at 1; rsp at 2; wb_valid at 3.
//    Split adds 2 cycles. Fault: wb_valid at 1.
// TESTING
//  - XLEN=32, LB addr 0x103, rsp 0x80FF_1234 -> mem_addr 0x100, wb_data 0xFFFF_FF80, wb_fault 0.
//  - LHU addr 0x102, rsp 0x8001_0000 -> wb_data 0x0000_8001; LH same -> 0xFFFF_8001.
//  - SPLIT_MIS=1, LW addr 0x0FE: rsp lo 0xAABB_CCDD at 0x0FC, hi 0x1122_3344 at 0x100 -> wb_data 0x3344_AABB.
//  - SPLIT_MIS=0, LW addr 0x0FE -> no mem_req_valid, wb_fault=1, wb_data=0 one cycle after accept.
//  - funct3=111 -> fault. Stall mem_req_ready 3 cycles and wb_ready 4 cycles -> mem_addr and wb outputs held stable.
//  - rst asserted in WAIT0, then late mem_rsp_valid -> outputs 0, req_ready=1, no wb_valid. XLEN=64 LWU 0x...FFFF_FFFF -> 0x0000_0000_FFFF_FFFF.

Source files
------------

// File: rtl/load_align_unit.sv
// Load-data alignment unit: issues one or two aligned word reads per load, merges and
// right-justifies the addressed bytes, and sign/zero-extends them for writeback.
module load_align_unit #(
    parameter int XLEN      = 32,
    parameter int SPLIT_MIS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_fault
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ0  = 3'd1;
    localparam logic [2:0] ST_WAIT0 = 3'd2;
    localparam logic [2:0] ST_REQ1  = 3'd3;
    localparam logic [2:0] ST_WAIT1 = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    logic [2:0]        state_r;
    logic [XLEN-1:0]   addr_r;
    logic [OFFW-1:0]   off_r;
    logic [2:0]        funct3_r;
    logic [4:0]        rd_r;
    logic              split_r;
    logic [XLEN-1:0]   lo_r;

    logic [OFFW-1:0]   off_s;
    logic [3:0]        size_s;
    logic [4:0]        end_s;
    logic              cross_s;
    logic              illegal_s;
    logic              fault_s;
    logic [XLEN-1:0]   aligned_s;
    logic [2*XLEN-1:0] cat_s;
    logic [2*XLEN-1:0] shifted_s;
    logic [XLEN-1:0]   load_s;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = XLEN'($signed(d[7:0]));
            3'b001:  r = XLEN'($signed(d[15:0]));
            3'b010:  r = XLEN'($signed(d[31:0]));
            3'b011:  r = d;
            3'b100:  r = XLEN'(d[7:0]);
            3'b101:  r = XLEN'(d[15:0]);
            3'b110:  r = XLEN'(d[31:0]);
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    assign off_s     = req_addr[OFFW-1:0];
    assign aligned_s = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign size_s    = 4'd1 << req_funct3[1:0];
    assign end_s     = {{(5-OFFW){1'b0}}, off_s} + {1'b0, size_s};
    assign cross_s   = end_s > 5'(BYTES);
    assign illegal_s = (req_funct3 == 3'b111) ||
                       ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    assign fault_s   = illegal_s || ((SPLIT_MIS == 0) && cross_s);

    // Merge the captured low word with the arriving word, then right-justify and extend
    always_comb begin
        if (state_r == ST_WAIT1) begin
            cat_s = {mem_rsp_data, lo_r};
        end else begin
            cat_s = {{XLEN{1'b0}}, mem_rsp_data};
        end
        shifted_s = cat_s >> {off_r, 3'b000};
        load_s    = extend(shifted_s[XLEN-1:0], funct3_r);
    end

    // Control sequencing with every handshake output held in a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            addr_r        <= {XLEN{1'b0}};
            off_r         <= {OFFW{1'b0}};
            funct3_r      <= 3'b000;
            rd_r          <= 5'd0;
            split_r       <= 1'b0;
            lo_r          <= {XLEN{1'b0}};
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= {XLEN{1'b0}};
            wb_valid      <= 1'b0;
            wb_data       <= {XLEN{1'b0}};
            wb_rd         <= 5'd0;
            wb_fault      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r    <= aligned_s;
                        off_r     <= off_s;
                        funct3_r  <= req_funct3;
                        rd_r      <= req_rd;
                        split_r   <= cross_s;
                        req_ready <= 1'b0;
                        if (fault_s) begin
                            state_r  <= ST_RESP;
                            wb_valid <= 1'b1;
                            wb_fault <= 1'b1;
                            wb_data  <= {XLEN{1'b0}};
                            wb_rd    <= req_rd;
                        end else begin
                            state_r       <= ST_REQ0;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= aligned_s;
                        end
                    end
                end
                ST_REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (mem_rsp_valid) begin
                        lo_r <= mem_rsp_data;
                        if (split_r) begin
                            state_r       <= ST_REQ1;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= addr_r + XLEN'(BYTES);
                        end else begin
                            state_r  <= ST_RESP;
                            wb_valid <= 1'b1;
                            wb_data  <= load_s;
                            wb_rd    <= rd_r;
                            wb_fault <= 1'b0;
                        end
                    end
                end
                ST_REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_r       <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (mem_rsp_valid) begin
                        state_r  <= ST_RESP;
                        wb_valid <= 1'b1;
                        wb_data  <= load_s;
                        wb_rd    <= rd_r;
                        wb_fault <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (wb_ready) begin
                        state_r   <= ST_IDLE;
                        req_ready <= 1'b1;
                        wb_valid  <= 1'b0;
                        wb_data   <= {XLEN{1'b0}};
                        wb_rd     <= 5'd0;
                        wb_fault  <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    req_ready     <= 1'b1;
                    mem_req_valid <= 1'b0;
                    wb_valid      <= 1'b0;
                end
            endcase
        end
    end
endmodule
